imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter RVC_EN, default 0; 1 enables compressed (16-bit) immediate decode.
REQ-003 SHALL have port iCLK, input, 1, sole clock; all state on its rising edge.
REQ-004 SHALL have port iRST, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port iInstrucao, input, 32, instruction; a compressed instruction occupies [15:0].
REQ-006 SHALL have port iValid, input, 1, iInstrucao valid.
REQ-007 SHALL have port oReady, output, 1, block accepts input this cycle.
REQ-008 SHALL have port iFlush, input, 1, discard all held entries.
REQ-009 SHALL have port oImm, output, XLEN, generated immediate.
REQ-010 SHALL have port oImmType, output, 3, format code: NONE, I, S, B, U, J, Z, CSRC.
REQ-011 SHALL have port oValid, output, 1, oImm/oImmType valid.
REQ-012 SHALL have port iReady, input, 1, consumer accepts output.

Function
REQ-013 SHALL accept a transfer when iValid and oReady are both high, and deliver it when oValid and iReady are both high.
REQ-014 SHALL present an accepted instruction on oImm/oImmType in the cycle after acceptance (latency 1) when the output register is empty or draining.
REQ-015 SHALL contain an output register plus one skid entry; oReady SHALL equal NOT skid-full and SHALL be a register output, with no combinational path from iReady.
REQ-016 SHALL, when oValid is high and iReady is low, hold oImm/oImmType stable and park one further accepted instruction in the skid entry.
REQ-017 SHALL, on delivery with the skid entry full, move the skid entry into the output register in the same edge and raise oReady the next cycle.
REQ-018 SHALL deliver instructions in acceptance order with no loss or duplication.
REQ-019 SHALL sign-extend from instruction bit 31 to XLEN for the RV32I/RV64I I, S, B, U and J formats (LOAD, FLOAD, OP-IMM, JALR, STORE, FSTORE, BRANCH, LUI, AUIPC, JAL); B and J SHALL have bit 0 forced to 0.
REQ-020 SHALL decode SYSTEM opcodes by funct3: CSRRWI/CSRRSI give a zero-extended [19:15] with type Z; CSRRCI gives the bitwise inverse of the zero-extended [19:15] with type CSRC; others give 0 with type NONE.
REQ-021 SHALL, when RVC_EN=1 and [1:0]!=2'b11, decode C.ADDI, C.LI, C.LUI, C.ADDI16SP, C.ADDI4SPN, C.LW, C.SW, C.LWSP, C.SWSP, C.J, C.JAL, C.BEQZ and C.BNEZ per the RVC spec; signed immediates SHALL be sign-extended and unsigned offsets zero-extended to XLEN.
REQ-022 SHALL output 0 with type NONE for an unsupported opcode, or for a compressed encoding when RVC_EN=0.
REQ-023 SHALL, on iFlush, clear oValid and the skid entry at the next edge and drop any iValid transfer in that cycle; flush takes priority over all simultaneous events.
REQ-024 SHALL hold oImm/oImmType at their last value while oValid is low.

Reset
REQ-025 SHALL, while iRST is high, immediately force oValid=0, skid empty, oImm=0, oImmType=NONE.
REQ-026 SHALL drive oReady=1 from the first edge after iRST deasserts; an asserted iRST mid-transfer SHALL discard both entries.

Structure
REQ-027 SHALL place the oImmType enumeration, opcode constants and funct3 constants in the shared parameter package; the RVC quadrant/funct3 codes SHALL be added there as well.
REQ-028 SHALL implement decoding as combinational sub-module imm_decode (XLEN, RVC_EN) feeding the handshake/skid logic in imm_gen_pipe.

Verification
REQ-029 SHALL cover: XLEN=32, 0xFFF00093 (addi x1,x0,-1) accepted -> next cycle oValid=1, oImm=0xFFFFFFFF, type I.
REQ-030 SHALL cover: 0xFE000EE3 (beq -4) -> oImm=0xFFFFFFFC, type B; CSRRCI with uimm=5 -> oImm=0xFFFFFFFA, type CSRC.
REQ-031 SHALL cover: RVC_EN=1, 0x50FD (c.li x1,-1) -> oImm=0xFFFFFFFF, type I; RVC_EN=0, same input -> oImm=0, type NONE.
REQ-032 SHALL cover: iReady=0 with three back-to-back valid inputs -> first held stable, second in skid, oReady=0 on third; releasing iReady delivers all three in order.
REQ-033 SHALL cover: iFlush with both entries full and iValid=1 -> oValid=0 next cycle, nothing delivered, oReady=1.
REQ-034 SHALL cover: XLEN=64, lui with imm 0x80000 -> oImm=0xFFFFFFFF80000000; iRST pulse mid-stall -> oValid drops without waiting for a clock edge.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg: shared constants for the immediate generator.
//   imm_type_e : format code driven on oImmType
//   OPC_*      : RV32I/RV64I major opcodes with an immediate
//   F3_*       : SYSTEM funct3 codes for the immediate CSR forms
//   C_Q*, C*_* : RVC quadrant and funct3 codes
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6,
        IMM_CSRC = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [1:0] C_Q0 = 2'b00;
    localparam logic [1:0] C_Q1 = 2'b01;
    localparam logic [1:0] C_Q2 = 2'b10;

    localparam logic [2:0] C0_ADDI4SPN = 3'b000;
    localparam logic [2:0] C0_LW       = 3'b010;
    localparam logic [2:0] C0_SW       = 3'b110;
    localparam logic [2:0] C1_ADDI     = 3'b000;
    localparam logic [2:0] C1_JAL      = 3'b001;
    localparam logic [2:0] C1_LI       = 3'b010;
    localparam logic [2:0] C1_LUI      = 3'b011;
    localparam logic [2:0] C1_J        = 3'b101;
    localparam logic [2:0] C1_BEQZ     = 3'b110;
    localparam logic [2:0] C1_BNEZ     = 3'b111;
    localparam logic [2:0] C2_LWSP     = 3'b010;
    localparam logic [2:0] C2_SWSP     = 3'b110;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle.
//   iInstrucao, iValid, oReady : input stream (compressed form in [15:0])
//   iFlush                     : discard everything held
//   oImm, oImmType, oValid, iReady : output stream
// master = producer/consumer side, slave = imm_gen_pipe side.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    import imm_gen_pipe_pkg::*;

    logic [31:0]     iInstrucao;
    logic            iValid;
    logic            oReady;
    logic            iFlush;
    logic [XLEN-1:0] oImm;
    imm_type_e       oImmType;
    logic            oValid;
    logic            iReady;

    modport master (
        output iInstrucao, iValid, iFlush, iReady,
        input  oReady, oImm, oImmType, oValid
    );

    modport slave (
        input  iInstrucao, iValid, iFlush, iReady,
        output oReady, oImm, oImmType, oValid
    );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: combinational immediate extraction.
//   instr : 32-bit instruction word (compressed form in [15:0])
//   imm   : immediate, extended to XLEN
//   itype : format code, IMM_NONE for anything not decoded
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RVC_EN = 0
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       itype
);

    // Every result fits a signed 32-bit value: unsigned offsets are small
    // (bit 31 clear) and the CSRC inverse has bit 31 set, so one sign
    // extension to XLEN gives the correct upper bits for all formats.
    logic signed [31:0] v;

    assign imm = XLEN'(v);

    always_comb begin
        v     = '0;
        itype = IMM_NONE;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OPC_LOAD, OPC_LOAD_FP, OPC_OP_IMM, OPC_JALR: begin
                    v     = {{20{instr[31]}}, instr[31:20]};
                    itype = IMM_I;
                end
                OPC_STORE, OPC_STORE_FP: begin
                    v     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                    itype = IMM_S;
                end
                OPC_BRANCH: begin
                    v     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                    itype = IMM_B;
                end
                OPC_LUI, OPC_AUIPC: begin
                    v     = {instr[31:12], 12'b0};
                    itype = IMM_U;
                end
                OPC_JAL: begin
                    v     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                    itype = IMM_J;
                end
                OPC_SYSTEM: begin
                    case (instr[14:12])
                        F3_CSRRWI, F3_CSRRSI: begin
                            v     = {27'b0, instr[19:15]};
                            itype = IMM_Z;
                        end
                        F3_CSRRCI: begin
                            v     = ~{27'b0, instr[19:15]};
                            itype = IMM_CSRC;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else if (RVC_EN != 0) begin
            case (instr[1:0])
                C_Q0: begin
                    case (instr[15:13])
                        C0_ADDI4SPN: begin
                            v     = {22'b0, instr[10:7], instr[12:11], instr[5], instr[6], 2'b00};
                            itype = IMM_I;
                        end
                        C0_LW: begin
                            v     = {25'b0, instr[5], instr[12:10], instr[6], 2'b00};
                            itype = IMM_I;
                        end
                        C0_SW: begin
                            v     = {25'b0, instr[5], instr[12:10], instr[6], 2'b00};
                            itype = IMM_S;
                        end
                        default: ;
                    endcase
                end
                C_Q1: begin
                    case (instr[15:13])
                        C1_ADDI, C1_LI: begin
                            v     = {{26{instr[12]}}, instr[12], instr[6:2]};
                            itype = IMM_I;
                        end
                        C1_JAL, C1_J: begin
                            // On RV64 this funct3 is C.ADDIW, which is not decoded here.
                            if (instr[15:13] == C1_J || XLEN == 32) begin
                                v     = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                                         instr[7], instr[2], instr[11], instr[5:3], 1'b0};
                                itype = IMM_J;
                            end
                        end
                        C1_LUI: begin
                            if (instr[11:7] == 5'd2) begin
                                v     = {{22{instr[12]}}, instr[12], instr[4:3], instr[5], instr[2],
                                         instr[6], 4'b0};
                                itype = IMM_I;
                            end else begin
                                v     = {{14{instr[12]}}, instr[12], instr[6:2], 12'b0};
                                itype = IMM_U;
                            end
                        end
                        C1_BEQZ, C1_BNEZ: begin
                            v     = {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                                     instr[4:3], 1'b0};
                            itype = IMM_B;
                        end
                        default: ;
                    endcase
                end
                C_Q2: begin
                    case (instr[15:13])
                        C2_LWSP: begin
                            v     = {24'b0, instr[3:2], instr[12], instr[6:4], 2'b00};
                            itype = IMM_I;
                        end
                        C2_SWSP: begin
                            v     = {24'b0, instr[8:7], instr[12:9], 2'b00};
                            itype = IMM_S;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator with output register and one skid entry.
//   iCLK, iRST : clock, asynchronous active-high reset
//   bus        : imm_gen_pipe_if slave (instruction in, immediate out,
//                flush); the interface XLEN must match this XLEN
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RVC_EN = 0
) (
    input  logic         iCLK,
    input  logic         iRST,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;

    logic            out_v;
    logic [XLEN-1:0] out_imm;
    imm_type_e       out_type;
    logic            skid_v;
    logic [XLEN-1:0] skid_imm;
    imm_type_e       skid_type;
    logic            rdy;
    logic            acc;

    imm_decode #(
        .XLEN   (XLEN),
        .RVC_EN (RVC_EN)
    ) u_decode (
        .instr (bus.iInstrucao),
        .imm   (dec_imm),
        .itype (dec_type)
    );

    assign acc          = bus.iValid && rdy;
    assign bus.oReady   = rdy;
    assign bus.oValid   = out_v;
    assign bus.oImm     = out_imm;
    assign bus.oImmType = out_type;

    // rdy is kept as its own flop (low through reset) and always equals the
    // inverse of the next skid state, so iReady never reaches oReady
    // combinationally.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            out_v     <= 1'b0;
            out_imm   <= '0;
            out_type  <= IMM_NONE;
            skid_v    <= 1'b0;
            skid_imm  <= '0;
            skid_type <= IMM_NONE;
            rdy       <= 1'b0;
        end else if (bus.iFlush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            rdy    <= 1'b1;
        end else if (out_v && !bus.iReady) begin
            if (acc) begin
                skid_v    <= 1'b1;
                skid_imm  <= dec_imm;
                skid_type <= dec_type;
            end
            rdy <= !(skid_v || acc);
        end else begin
            if (skid_v) begin
                out_v    <= 1'b1;
                out_imm  <= skid_imm;
                out_type <= skid_type;
                skid_v   <= 1'b0;
            end else begin
                out_v <= acc;
                if (acc) begin
                    out_imm  <= dec_imm;
                    out_type <= dec_type;
                end
            end
            rdy <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [63:0] imm;
        imm_type_e   ty;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] t_instr = '0;
    logic        t_valid = 1'b0;
    logic        t_ready = 1'b0;
    logic        t_flush = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    logic [31:0] last = '0;
    bit          have_last = 0;
    bit          mrdy = 0;
    bit          rdy_known = 0;

    vec_t vecs[17];
    logic [6:0] opcs[12];

    imm_gen_pipe_if #(.XLEN(32)) b32c ();
    imm_gen_pipe_if #(.XLEN(32)) b32n ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    assign b32c.iInstrucao = t_instr;
    assign b32c.iValid     = t_valid;
    assign b32c.iReady     = t_ready;
    assign b32c.iFlush     = t_flush;
    assign b32n.iInstrucao = t_instr;
    assign b32n.iValid     = t_valid;
    assign b32n.iReady     = t_ready;
    assign b32n.iFlush     = t_flush;
    assign b64.iInstrucao  = t_instr;
    assign b64.iValid      = t_valid;
    assign b64.iReady      = t_ready;
    assign b64.iFlush      = t_flush;

    imm_gen_pipe #(.XLEN(32), .RVC_EN(1)) dut32c (.iCLK(clk), .iRST(rst), .bus(b32c));
    imm_gen_pipe #(.XLEN(32), .RVC_EN(0)) dut32n (.iCLK(clk), .iRST(rst), .bus(b32n));
    imm_gen_pipe #(.XLEN(64), .RVC_EN(1)) dut64  (.iCLK(clk), .iRST(rst), .bus(b64));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint fld(logic [31:0] x, int hi, int lo);
        return (longint'({32'b0, x}) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    function automatic longint sx(longint v, int bits);
        return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
    endfunction

    function automatic void ref_dec(input logic [31:0] x, input bit rvc, input bit x64,
                                    output logic [63:0] imm, output imm_type_e ty);
        longint v = 0;
        longint jofs;
        ty = IMM_NONE;
        jofs = sx(fld(x,12,12)*2048 + fld(x,11,11)*16 + fld(x,10,9)*256 + fld(x,8,8)*1024
                  + fld(x,7,7)*64 + fld(x,6,6)*128 + fld(x,5,3)*2 + fld(x,2,2)*32, 12);
        if (fld(x,1,0) == 3) begin
            case (fld(x,6,0))
                'h03, 'h07, 'h13, 'h67: begin v = sx(fld(x,31,20), 12); ty = IMM_I; end
                'h23, 'h27: begin v = sx(fld(x,31,25)*32 + fld(x,11,7), 12); ty = IMM_S; end
                'h63: begin
                    v = sx(fld(x,31,31)*4096 + fld(x,7,7)*2048 + fld(x,30,25)*32 + fld(x,11,8)*2, 13);
                    ty = IMM_B;
                end
                'h37, 'h17: begin v = sx(fld(x,31,12)*4096, 32); ty = IMM_U; end
                'h6f: begin
                    v = sx(fld(x,31,31)*(longint'(1) << 20) + fld(x,19,12)*4096
                           + fld(x,20,20)*2048 + fld(x,30,21)*2, 21);
                    ty = IMM_J;
                end
                'h73: begin
                    case (fld(x,14,12))
                        5, 6: begin v = fld(x,19,15); ty = IMM_Z; end
                        7:    begin v = ~fld(x,19,15); ty = IMM_CSRC; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end else if (rvc) begin
            case (fld(x,1,0)*8 + fld(x,15,13))
                0:  begin v = fld(x,10,7)*64 + fld(x,12,11)*16 + fld(x,5,5)*8 + fld(x,6,6)*4; ty = IMM_I; end
                2:  begin v = fld(x,12,10)*8 + fld(x,6,6)*4 + fld(x,5,5)*64; ty = IMM_I; end
                6:  begin v = fld(x,12,10)*8 + fld(x,6,6)*4 + fld(x,5,5)*64; ty = IMM_S; end
                8, 10: begin v = sx(fld(x,12,12)*32 + fld(x,6,2), 6); ty = IMM_I; end
                9:  if (!x64) begin v = jofs; ty = IMM_J; end
                11: begin
                    if (fld(x,11,7) == 2) begin
                        v = sx(fld(x,12,12)*512 + fld(x,4,3)*128 + fld(x,5,5)*64
                               + fld(x,2,2)*32 + fld(x,6,6)*16, 10);
                        ty = IMM_I;
                    end else begin
                        v = sx(fld(x,12,12)*131072 + fld(x,6,2)*4096, 18);
                        ty = IMM_U;
                    end
                end
                13: begin v = jofs; ty = IMM_J; end
                14, 15: begin
                    v = sx(fld(x,12,12)*256 + fld(x,6,5)*64 + fld(x,2,2)*32
                           + fld(x,11,10)*8 + fld(x,4,3)*2, 9);
                    ty = IMM_B;
                end
                18: begin v = fld(x,12,12)*32 + fld(x,6,4)*4 + fld(x,3,2)*64; ty = IMM_I; end
                22: begin v = fld(x,12,9)*4 + fld(x,8,7)*64; ty = IMM_S; end
                default: ;
            endcase
        end
        imm = x64 ? 64'(v) : {32'b0, 32'(v)};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
        end
    endtask

    function automatic void exp_for(input bit rvc, input bit x64,
                                    output logic [63:0] e, output imm_type_e et);
        if (q.size() > 0) ref_dec(q[0], rvc, x64, e, et);
        else if (have_last) ref_dec(last, rvc, x64, e, et);
        else begin e = '0; et = IMM_NONE; end
    endfunction

    task automatic check_all();
        logic [63:0] e;
        imm_type_e   et;
        bit          ev;
        ev = (q.size() > 0);
        chk("valid_32c", 64'(b32c.oValid), 64'(ev));
        chk("valid_32n", 64'(b32n.oValid), 64'(ev));
        chk("valid_64",  64'(b64.oValid),  64'(ev));
        if (rdy_known) begin
            chk("ready_32c", 64'(b32c.oReady), 64'(mrdy));
            chk("ready_32n", 64'(b32n.oReady), 64'(mrdy));
            chk("ready_64",  64'(b64.oReady),  64'(mrdy));
        end
        exp_for(1, 0, e, et);
        chk("imm_32c", 64'(b32c.oImm), e);
        chk("type_32c", 64'(b32c.oImmType), 64'(et));
        exp_for(0, 0, e, et);
        chk("imm_32n", 64'(b32n.oImm), e);
        chk("type_32n", 64'(b32n.oImmType), 64'(et));
        exp_for(1, 1, e, et);
        chk("imm_64", b64.oImm, e);
        chk("type_64", 64'(b64.oImmType), 64'(et));
    endtask

    task automatic step(input bit v, input logic [31:0] ins, input bit r, input bit fl);
        bit acc, del;
        t_valid = v; t_instr = ins; t_ready = r; t_flush = fl;
        @(posedge clk);
        acc = v && mrdy && !fl;
        del = (q.size() > 0) && r && !fl;
        if (fl) q.delete();
        else begin
            if (del) void'(q.pop_front());
            if (acc) q.push_back(ins);
        end
        mrdy = (q.size() < 2);
        rdy_known = 1;
        if (q.size() > 0) begin last = q[0]; have_last = 1; end
        #1;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        have_last = 0;
        rdy_known = 0;
        mrdy = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        logic [1:0]  cq;

        vecs[0]  = '{"addi_m1",    32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I};
        vecs[1]  = '{"beq_m4",     32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, IMM_B};
        vecs[2]  = '{"csrrci_5",   32'h3002F073, 64'hFFFF_FFFF_FFFF_FFFA, IMM_CSRC};
        vecs[3]  = '{"csrrwi_3",   32'h3001D073, 64'h0000_0000_0000_0003, IMM_Z};
        vecs[4]  = '{"csrrsi_31",  32'h300FE073, 64'h0000_0000_0000_001F, IMM_Z};
        vecs[5]  = '{"c_li_m1",    32'h000050FD, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I};
        vecs[6]  = '{"lui_80000",  32'h800000B7, 64'hFFFF_FFFF_8000_0000, IMM_U};
        vecs[7]  = '{"sw_m8",      32'hFE112C23, 64'hFFFF_FFFF_FFFF_FFF8, IMM_S};
        vecs[8]  = '{"jal_800",    32'h0010006F, 64'h0000_0000_0000_0800, IMM_J};
        vecs[9]  = '{"ecall",      32'h00000073, 64'h0,                   IMM_NONE};
        vecs[10] = '{"add_unsup",  32'h002081B3, 64'h0,                   IMM_NONE};
        vecs[11] = '{"c_j_m2",     32'h0000BFFD, 64'hFFFF_FFFF_FFFF_FFFE, IMM_J};
        vecs[12] = '{"c_addi4spn", 32'h00000040, 64'h0000_0000_0000_0004, IMM_I};
        vecs[13] = '{"c_sw_64",    32'h0000C020, 64'h0000_0000_0000_0040, IMM_S};
        vecs[14] = '{"c_bnez_m256",32'h0000F001, 64'hFFFF_FFFF_FFFF_FF00, IMM_B};
        vecs[15] = '{"c_lui_1",    32'h00006085, 64'h0000_0000_0000_1000, IMM_U};
        vecs[16] = '{"c_a16sp_m16",32'h0000717D, 64'hFFFF_FFFF_FFFF_FFF0, IMM_I};

        opcs = '{7'h03, 7'h07, 7'h13, 7'h67, 7'h23, 7'h27, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};

        // reset: outputs forced without a clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 64'(b32c.oValid), 64'd0);
        chk("rst_imm", b64.oImm, 64'd0);
        chk("rst_type", 64'(b32c.oImmType), 64'(IMM_NONE));
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step(0, '0, 1, 0);
        chk("ready_after_rst", 64'(b32c.oReady), 64'd1);

        // table-driven vectors, one at a time with latency 1
        foreach (vecs[i]) begin
            step(1, vecs[i].ins, 1, 0);
            chk({vecs[i].name, "_v"}, 64'(b32c.oValid), 64'd1);
            chk({vecs[i].name, "_32c"}, 64'(b32c.oImm), {32'b0, vecs[i].imm[31:0]});
            chk({vecs[i].name, "_32c_t"}, 64'(b32c.oImmType), 64'(vecs[i].ty));
            chk({vecs[i].name, "_64"}, b64.oImm, vecs[i].imm);
            chk({vecs[i].name, "_64_t"}, 64'(b64.oImmType), 64'(vecs[i].ty));
            if (vecs[i].ins[1:0] != 2'b11) begin
                chk({vecs[i].name, "_32n"}, 64'(b32n.oImm), 64'd0);
                chk({vecs[i].name, "_32n_t"}, 64'(b32n.oImmType), 64'(IMM_NONE));
            end else begin
                chk({vecs[i].name, "_32n"}, 64'(b32n.oImm), {32'b0, vecs[i].imm[31:0]});
                chk({vecs[i].name, "_32n_t"}, 64'(b32n.oImmType), 64'(vecs[i].ty));
            end
            step(0, '0, 1, 0);
        end

        // stall: three back-to-back inputs with iReady low, then release
        step(1, 32'hFFF00093, 0, 0);
        chk("stall_a_imm", 64'(b32c.oImm), 64'hFFFF_FFFF);
        step(1, 32'hFE000EE3, 0, 0);
        chk("stall_a_held", 64'(b32c.oImm), 64'hFFFF_FFFF);
        chk("stall_skid_full", 64'(b32c.oReady), 64'd0);
        step(1, 32'h3002F073, 0, 0);
        chk("stall_c_blocked", 64'(b32c.oReady), 64'd0);
        chk("stall_a_held2", 64'(b32c.oImm), 64'hFFFF_FFFF);
        step(1, 32'h3002F073, 1, 0);
        chk("rel_b_imm", 64'(b32c.oImm), 64'hFFFF_FFFC);
        chk("rel_ready_up", 64'(b32c.oReady), 64'd1);
        step(1, 32'h3002F073, 1, 0);
        chk("rel_c_imm", 64'(b32c.oImm), 64'hFFFF_FFFA);
        chk("rel_c_type", 64'(b32c.oImmType), 64'(IMM_CSRC));
        step(0, '0, 1, 0);
        chk("rel_empty", 64'(b32c.oValid), 64'd0);

        // flush with both entries full and a valid input
        step(1, 32'hFFF00093, 0, 0);
        step(1, 32'hFE000EE3, 0, 0);
        step(1, 32'h3002F073, 0, 1);
        chk("flush_valid", 64'(b32c.oValid), 64'd0);
        chk("flush_ready", 64'(b32c.oReady), 64'd1);
        step(0, '0, 1, 0);
        chk("flush_nothing", 64'(b64.oValid), 64'd0);
        chk("flush_hold_imm", 64'(b32c.oImm), 64'hFFFF_FFFF);

        // reset pulse mid-stall
        step(1, 32'h800000B7, 0, 0);
        step(1, 32'hFE000EE3, 0, 0);
        chk("pre_rst_64", b64.oImm, 64'hFFFF_FFFF_8000_0000);
        rst = 1'b1;
        #1;
        chk("midrst_valid_32c", 64'(b32c.oValid), 64'd0);
        chk("midrst_valid_64", 64'(b64.oValid), 64'd0);
        chk("midrst_imm_64", b64.oImm, 64'd0);
        chk("midrst_type_64", 64'(b64.oImmType), 64'(IMM_NONE));
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step(0, '0, 1, 0);
        chk("postrst_ready", 64'(b64.oReady), 64'd1);

        // randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            case ($urandom_range(0, 3))
                0: ins = $urandom;
                1: ins = {r[31:7], opcs[$urandom_range(0, 11)]};
                2: begin
                    cq  = 2'($urandom_range(0, 2));
                    ins = {r[31:2], cq};
                end
                default: ins = {r[31:15], 3'($urandom_range(0, 7)), r[11:7], 7'h73};
            endcase
            step($urandom_range(0, 9) < 6, ins, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0);
        end
        for (int n = 0; n < 4; n++) step(0, '0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
